// File: rtl/serial_pix_receiver_pkg.sv
// Shared types and constants for the serial pixel link receiver.
// State encoding, default word width and bit-counter sizing helper.
package serial_pix_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 12;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int BIT_CNT_W = cnt_width(DATA_W_DEF);

endpackage

// File: rtl/serial_pix_receiver_if.sv
// Word-side valid/ready port of the serial pixel receiver.
// The receiver drives the master side, the pixel consumer the slave side.
interface serial_pix_receiver_if
  import serial_pix_receiver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/serial_pix_receiver_edge_sync.sv
// Two-flop synchronizer with a rising-edge pulse on the synchronized level.
// RST_VAL lets a high-idle line come out of reset without a false edge.
module edge_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync,
  output logic rise
);
  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
endmodule

// File: rtl/serial_pix_receiver.sv
// Oversampling receiver for the Serck/Serot pixel link, delivering words on a valid/ready port.
// Define SERIAL_PIX_PARITY_EN to expect an even-parity bit between data and stop.
module serial_pix_receiver
  import serial_pix_receiver_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Serck,
  input  logic                  Serot,
  serial_pix_receiver_if.master pix,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  err_clr,
  output logic                  busy
);
  localparam int BCNT_W = cnt_width(DATA_W);
  localparam int TO_W   = $clog2(TIMEOUT);

  logic              rise;
  logic              ser_bit;
  logic              sck_level_unused;
  logic              sdo_rise_unused;
  state_t            state;
  logic [BCNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] shift_p0;
  logic              deliver_p0;
  logic              err_p0;
`ifdef SERIAL_PIX_PARITY_EN
  logic              par_bad;
`endif

  edge_sync #(.RST_VAL(1'b1)) u_sck_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (Serck),
    .sync     (sck_level_unused),
    .rise     (rise)
  );

  edge_sync #(.RST_VAL(1'b1)) u_sdo_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (Serot),
    .sync     (ser_bit),
    .rise     (sdo_rise_unused)
  );

  assign busy = (state != ST_IDLE);

  // Stage p0: frame FSM, bit/timeout counters and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      deliver_p0 <= 1'b0;
      err_p0     <= 1'b0;
`ifdef SERIAL_PIX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      deliver_p0 <= 1'b0;
      err_p0     <= 1'b0;
      to_cnt     <= (state == ST_IDLE || rise) ? '0 : to_cnt + 1'b1;
      // abort on the cycle the idle count reaches TIMEOUT-1
      if (state != ST_IDLE && !rise && to_cnt == TO_W'(TIMEOUT - 2)) begin
        state  <= ST_IDLE;
        err_p0 <= 1'b1;
      end else if (rise) begin
        case (state)
          ST_IDLE: begin
            if (!ser_bit) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BCNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_PIX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
`ifdef SERIAL_PIX_PARITY_EN
          ST_PARITY: begin
            par_bad <= (^shift_p0) ^ ser_bit;
            state   <= ST_STOP;
          end
`endif
          ST_STOP: begin
            state <= ST_IDLE;
`ifdef SERIAL_PIX_PARITY_EN
            if (ser_bit && !par_bad) deliver_p0 <= 1'b1;
            else                     err_p0     <= 1'b1;
`else
            if (ser_bit) deliver_p0 <= 1'b1;
            else         err_p0     <= 1'b1;
`endif
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rise && state == ST_DATA) shift_p0 <= {shift_p0[DATA_W-2:0], ser_bit};
  end

  // Stage p1: word port, error pulse and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix.pix_data  <= '0;
      pix.pix_valid <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_err <= err_p0;
      if (deliver_p0) begin
        pix.pix_data  <= shift_p0;
        pix.pix_valid <= 1'b1;
      end else if (pix.pix_ready) begin
        pix.pix_valid <= 1'b0;
      end
      if (deliver_p0 && pix.pix_valid && !pix.pix_ready) overrun <= 1'b1;
      else if (err_clr)                                  overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_pix_receiver.sv
// Directed bench for serial_pix_receiver: table of frames plus hand sequences
// for overrun, latency, timeout and mid-frame reset.
module tb_serial_pix_receiver;

  logic clk = 1'b0;
  logic rst;
  logic Serck;
  logic Serot;
  logic frame_err;
  logic overrun;
  logic err_clr;
  logic busy;

  serial_pix_receiver_if #(.DATA_W(12)) pif ();

  serial_pix_receiver #(.DATA_W(12), .TIMEOUT(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .Serck     (Serck),
    .Serot     (Serot),
    .pix       (pif),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hs_cnt  = 0;
  int err_cnt = 0;
  logic [11:0] last_word = '0;
  logic cur_par_flip = 1'b0;

  typedef struct {
    logic [11:0] word;
    logic        stop;
    logic        par_flip;
  } vec_t;

  vec_t vecs[$];

  always @(negedge clk) begin
    if (pif.pix_valid && pif.pix_ready) begin
      hs_cnt++;
      last_word = pif.pix_data;
    end
    if (frame_err) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ser_bit_lead(input logic b);
    Serck = 1'b0;
    Serot = b;
    repeat (4) @(negedge clk);
    Serck = 1'b1;
  endtask

  task automatic ser_bit(input logic b);
    ser_bit_lead(b);
    repeat (4) @(negedge clk);
  endtask

  // returns right after the stop-bit Serck rise is driven
  task automatic send_frame(input logic [11:0] w, input logic stop);
    ser_bit(1'b0);
    for (int i = 11; i >= 0; i--) ser_bit(w[i]);
`ifdef SERIAL_PIX_PARITY_EN
    ser_bit((^w) ^ cur_par_flip);
`endif
    ser_bit_lead(stop);
  endtask

  initial begin
    int hs0;
    int er0;
    int t;
    logic exp_good;
    logic [11:0] w;

    rst = 1'b1;
    Serck = 1'b1;
    Serot = 1'b1;
    err_clr = 1'b0;
    pif.pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset pix_valid", 32'(pif.pix_valid), 32'd0);
    check("reset pix_data", 32'(pif.pix_data), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    vecs.push_back('{12'hA5C, 1'b1, 1'b0});
    vecs.push_back('{12'h123, 1'b0, 1'b0});
    vecs.push_back('{12'h456, 1'b1, 1'b0});
    vecs.push_back('{12'h000, 1'b1, 1'b0});
    vecs.push_back('{12'hFFF, 1'b1, 1'b0});
    vecs.push_back('{12'h800, 1'b0, 1'b0});
`ifdef SERIAL_PIX_PARITY_EN
    vecs.push_back('{12'h0F0, 1'b1, 1'b0});
    vecs.push_back('{12'h0F1, 1'b1, 1'b1});
    vecs.push_back('{12'h0F1, 1'b1, 1'b0});
`endif

    foreach (vecs[k]) begin
      hs0 = hs_cnt;
      er0 = err_cnt;
      cur_par_flip = vecs[k].par_flip;
      exp_good = vecs[k].stop && !vecs[k].par_flip;
      send_frame(vecs[k].word, vecs[k].stop);
      repeat (12) @(negedge clk);
      Serot = 1'b1;
      check($sformatf("vec%0d frame_err count", k), 32'(err_cnt - er0), exp_good ? 32'd0 : 32'd1);
      check($sformatf("vec%0d handshake count", k), 32'(hs_cnt - hs0), exp_good ? 32'd1 : 32'd0);
      if (exp_good) check($sformatf("vec%0d word", k), 32'(last_word), 32'(vecs[k].word));
      else          check($sformatf("vec%0d pix_valid", k), 32'(pif.pix_valid), 32'd0);
      check($sformatf("vec%0d overrun", k), 32'(overrun), 32'd0);
    end
    cur_par_flip = 1'b0;

    // back-to-back words with no consumer
    pif.pix_ready = 1'b0;
    send_frame(12'h001, 1'b1);
    repeat (6) @(negedge clk);
    Serot = 1'b1;
    check("b2b first valid", 32'(pif.pix_valid), 32'd1);
    check("b2b first overrun", 32'(overrun), 32'd0);
    send_frame(12'hFFF, 1'b1);
    repeat (6) @(negedge clk);
    Serot = 1'b1;
    check("b2b data", 32'(pif.pix_data), 32'hFFF);
    check("b2b valid", 32'(pif.pix_valid), 32'd1);
    check("b2b overrun", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr overrun", 32'(overrun), 32'd0);
    check("err_clr keeps valid", 32'(pif.pix_valid), 32'd1);
    pif.pix_ready = 1'b1;
    @(negedge clk);
    check("consume clears valid", 32'(pif.pix_valid), 32'd0);

    // delivery and error latency from the stop-bit Serck rise
    send_frame(12'h5A5, 1'b1);
    repeat (3) @(negedge clk);
    check("latency valid early", 32'(pif.pix_valid), 32'd0);
    @(negedge clk);
    check("latency valid", 32'(pif.pix_valid), 32'd1);
    check("latency data", 32'(pif.pix_data), 32'h5A5);
    repeat (6) @(negedge clk);
    Serot = 1'b1;
    send_frame(12'h3AA, 1'b0);
    repeat (3) @(negedge clk);
    check("err latency early", 32'(frame_err), 32'd0);
    @(negedge clk);
    check("err pulse", 32'(frame_err), 32'd1);
    @(negedge clk);
    check("err one cycle", 32'(frame_err), 32'd0);
    repeat (6) @(negedge clk);
    Serot = 1'b1;

    // stall after 5 data bits
    w = 12'hABC;
    ser_bit(1'b0);
    for (int i = 11; i > 7; i--) ser_bit(w[i]);
    ser_bit_lead(w[7]);
    t = 0;
    while (!frame_err && t < 1200) begin
      @(negedge clk);
      t++;
      if (t == 10) check("stall busy", 32'(busy), 32'd1);
    end
    check("timeout window", 32'((t >= 1020) && (t <= 1030)), 32'd1);
    @(negedge clk);
    check("timeout busy", 32'(busy), 32'd0);
    check("timeout valid", 32'(pif.pix_valid), 32'd0);
    Serot = 1'b1;
    hs0 = hs_cnt;
    send_frame(12'h789, 1'b1);
    repeat (12) @(negedge clk);
    check("after timeout count", 32'(hs_cnt - hs0), 32'd1);
    check("after timeout word", 32'(last_word), 32'h789);

    // reset in the middle of a frame
    w = 12'hE5D;
    er0 = err_cnt;
    ser_bit(1'b0);
    for (int i = 11; i > 4; i--) ser_bit(w[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst pix_valid", 32'(pif.pix_valid), 32'd0);
    check("midrst pix_data", 32'(pif.pix_data), 32'd0);
    check("midrst frame_err", 32'(frame_err), 32'd0);
    check("midrst overrun", 32'(overrun), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    Serot = 1'b1;
    hs0 = hs_cnt;
    send_frame(12'h3C3, 1'b1);
    repeat (12) @(negedge clk);
    check("midrst no frame_err", 32'(err_cnt - er0), 32'd0);
    check("after rst count", 32'(hs_cnt - hs0), 32'd1);
    check("after rst word", 32'(last_word), 32'h3C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
